// File: rtl/rd_stream_adapter.sv
// -----------------------------------------------------------------------------
// rd_stream_adapter
// Read-side consumer of an async FIFO, living entirely in the read clock domain.
// It issues FIFO pops from the registered empty flag, absorbs the one-cycle
// registered memory read latency, and presents the words on a valid/ready
// stream through a 2-entry skid buffer, so one word per cycle is sustained.
// A flush sequence drains and discards everything left in the FIFO.
//
// Ports:
//   rclk_i        read clock
//   rrst_n_i      asynchronous active-low reset
//   en_i          level, permits issuing new pops
//   flush_i       single-cycle pulse, starts a flush
//   fifo_empty_i  registered FIFO empty flag
//   ren_o         pop request; the FIFO pops at the edge where ren_o=1
//   rdata_i       memory read data, valid one cycle after the ren_o edge
//   m_valid_o     stream valid
//   m_data_o      stream data (head of the skid buffer)
//   m_ready_i     stream ready
//   busy_o        flushing, word in flight, or words buffered
//   flush_done_o  one-cycle pulse in the cycle a flush completes
//   beat_cnt_o    count of accepted stream beats (wraps)
// -----------------------------------------------------------------------------
module rd_stream_adapter #(
    parameter int DSIZE = 8,
    parameter int CNT_W = 16
) (
    input  logic             rclk_i,
    input  logic             rrst_n_i,
    input  logic             en_i,
    input  logic             flush_i,
    input  logic             fifo_empty_i,
    output logic             ren_o,
    input  logic [DSIZE-1:0] rdata_i,
    output logic             m_valid_o,
    output logic [DSIZE-1:0] m_data_o,
    input  logic             m_ready_i,
    output logic             busy_o,
    output logic             flush_done_o,
    output logic [CNT_W-1:0] beat_cnt_o
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_FLUSH = 2'd2;

    logic [1:0]       state_r;
    logic [1:0]       state_nxt_s;
    logic             inflight_r;
    logic [1:0]       buf_cnt_r;
    logic [DSIZE-1:0] buf_mem_r [2];
    logic             rd_ptr_r;
    logic             wr_ptr_r;
    logic [CNT_W-1:0] beat_cnt_r;

    logic [2:0]       occ_s;
    logic             ren_s;
    logic             pop_s;
    logic             push_s;
    logic             flush_start_s;
    logic             flush_exit_s;

    // Buffer credit in use: words held plus the word returning next edge.
    assign occ_s         = {1'b0, buf_cnt_r} + {2'b00, inflight_r};
    assign m_valid_o     = (buf_cnt_r != 2'd0);
    assign m_data_o      = buf_mem_r[rd_ptr_r];
    assign pop_s         = m_valid_o && m_ready_i;
    assign flush_start_s = flush_i && (state_r != ST_FLUSH);
    // A flush is complete once the FIFO is empty and no pop is outstanding.
    assign flush_exit_s  = (state_r == ST_FLUSH) && fifo_empty_i && !inflight_r && !ren_s;
    // Returning words are dropped while flushing and at the flush-entry edge.
    assign push_s        = inflight_r && (state_r != ST_FLUSH) && !flush_start_s;

    assign ren_o         = ren_s;
    assign flush_done_o  = flush_exit_s;
    assign busy_o        = (state_r == ST_FLUSH) || inflight_r || (buf_cnt_r != 2'd0);
    assign beat_cnt_o    = beat_cnt_r;

    // Pop issue: in RUN a slot at occupancy 2 may be reused only when the
    // head leaves at this same edge, which keeps the buffer at most 2 deep.
    always_comb begin
        ren_s = 1'b0;
        case (state_r)
            ST_RUN: begin
                if (!fifo_empty_i &&
                    ((occ_s < 3'd2) || ((occ_s == 3'd2) && pop_s))) begin
                    ren_s = 1'b1;
                end else begin
                    ren_s = 1'b0;
                end
            end
            ST_FLUSH: ren_s = !fifo_empty_i;
            default:  ren_s = 1'b0;
        endcase
    end

    // Next-state selection; flush_i outranks en_i.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (flush_i) begin
                    state_nxt_s = ST_FLUSH;
                end else if (en_i) begin
                    state_nxt_s = ST_RUN;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (flush_i) begin
                    state_nxt_s = ST_FLUSH;
                end else if (!en_i) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_RUN;
                end
            end
            ST_FLUSH: begin
                if (flush_exit_s) begin
                    state_nxt_s = en_i ? ST_RUN : ST_IDLE;
                end else begin
                    state_nxt_s = ST_FLUSH;
                end
            end
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // State register and in-flight tracking of the registered read return.
    always_ff @(posedge rclk_i or negedge rrst_n_i) begin
        if (!rrst_n_i) begin
            state_r    <= ST_IDLE;
            inflight_r <= 1'b0;
        end else begin
            state_r    <= state_nxt_s;
            inflight_r <= ren_s;
        end
    end

    // Skid buffer occupancy and pointers; flush entry empties it at once.
    always_ff @(posedge rclk_i or negedge rrst_n_i) begin
        if (!rrst_n_i) begin
            buf_cnt_r <= 2'd0;
            rd_ptr_r  <= 1'b0;
            wr_ptr_r  <= 1'b0;
        end else if (flush_start_s) begin
            buf_cnt_r <= 2'd0;
            rd_ptr_r  <= 1'b0;
            wr_ptr_r  <= 1'b0;
        end else begin
            if (push_s) begin
                wr_ptr_r <= ~wr_ptr_r;
            end
            if (pop_s) begin
                rd_ptr_r <= ~rd_ptr_r;
            end
            case ({push_s, pop_s})
                2'b10:   buf_cnt_r <= buf_cnt_r + 2'd1;
                2'b01:   buf_cnt_r <= buf_cnt_r - 2'd1;
                default: buf_cnt_r <= buf_cnt_r;
            endcase
        end
    end

    // Skid buffer storage, written with the captured read data.
    always_ff @(posedge rclk_i or negedge rrst_n_i) begin
        if (!rrst_n_i) begin
            for (int i = 0; i < 2; i++) begin
                buf_mem_r[i] <= {DSIZE{1'b0}};
            end
        end else if (push_s) begin
            buf_mem_r[wr_ptr_r] <= rdata_i;
        end
    end

    // Accepted-beat counter, wraps naturally at its width.
    always_ff @(posedge rclk_i or negedge rrst_n_i) begin
        if (!rrst_n_i) begin
            beat_cnt_r <= {CNT_W{1'b0}};
        end else if (pop_s) begin
            beat_cnt_r <= beat_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

endmodule
